// File: rtl/rename_regfile.sv
// rename_regfile: 32x32 architectural register file with per-register ROB rename state.
// Ports: clk, rst_n (async active-low), rdy (global enable), rollback (flush renames),
//   issue_valid/issue_rd/issue_tag (rename rd at issue),
//   commit_valid/commit_rd/commit_rdTag/commit_rdVal (ROB commit),
//   rs1/rs2 -> rsX_val/rsX_busy/rsX_tag (combinational reads).
// Optional macro RF_COMMIT_BYPASS_EN: a matching same-cycle commit shows on the read ports.
module rename_regfile #(
  parameter int ROB_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [ROB_W-1:0] issue_tag,
  input  logic             commit_valid,
  input  logic [4:0]       commit_rd,
  input  logic [ROB_W-1:0] commit_rdTag,
  input  logic [31:0]      commit_rdVal,
  input  logic [4:0]       rs1,
  output logic [31:0]      rs1_val,
  output logic             rs1_busy,
  output logic [ROB_W-1:0] rs1_tag,
  input  logic [4:0]       rs2,
  output logic [31:0]      rs2_val,
  output logic             rs2_busy,
  output logic [ROB_W-1:0] rs2_tag
);

  logic [31:0]      val_q  [32];
  logic [31:0]      val_d  [32];
  logic [31:0]      busy_q;
  logic [31:0]      busy_d;
  logic [ROB_W-1:0] tag_q  [32];
  logic [ROB_W-1:0] tag_d  [32];

  logic commit_we;
  logic commit_clr;
  logic issue_we;

  assign commit_we  = commit_valid && (commit_rd != 5'd0);
  // Only the rename that produced this commit may be released;
  // a newer rename with a different tag stays busy.
  assign commit_clr = commit_we && busy_q[commit_rd]
                      && (tag_q[commit_rd] == commit_rdTag);
  assign issue_we   = issue_valid && (issue_rd != 5'd0) && !rollback;

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (commit_we) begin
        val_d[commit_rd] = commit_rdVal;
      end
      if (commit_clr) begin
        busy_d[commit_rd] = 1'b0;
      end
      if (rollback) begin
        busy_d = '0;
        for (int i = 0; i < 32; i++) begin
          tag_d[i] = '0;
        end
      end
      // Issue is applied last so it wins over a same-cycle commit clear.
      if (issue_we) begin
        busy_d[issue_rd] = 1'b1;
        tag_d[issue_rd]  = issue_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

`ifdef RF_COMMIT_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = rdy && commit_valid && (rs1 != 5'd0)
                && (commit_rd == rs1) && busy_q[rs1]
                && (tag_q[rs1] == commit_rdTag);
  assign byp2 = rdy && commit_valid && (rs2 != 5'd0)
                && (commit_rd == rs2) && busy_q[rs2]
                && (tag_q[rs2] == commit_rdTag);
`else
  logic byp1;
  logic byp2;

  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    rs1_val  = '0;
    rs1_busy = 1'b0;
    rs1_tag  = '0;
    if (rs1 != 5'd0) begin
      rs1_val  = byp1 ? commit_rdVal : val_q[rs1];
      rs1_busy = byp1 ? 1'b0 : busy_q[rs1];
      rs1_tag  = tag_q[rs1];
    end
  end

  always_comb begin
    rs2_val  = '0;
    rs2_busy = 1'b0;
    rs2_tag  = '0;
    if (rs2 != 5'd0) begin
      rs2_val  = byp2 ? commit_rdVal : val_q[rs2];
      rs2_busy = byp2 ? 1'b0 : busy_q[rs2];
      rs2_tag  = tag_q[rs2];
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
// tb_rename_regfile: directed + random checks of rename_regfile
// against an array-based reference model.
module tb_rename_regfile;
  localparam int ROB_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rdy;
  logic             rollback;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [ROB_W-1:0] issue_tag;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [ROB_W-1:0] commit_rdTag;
  logic [31:0]      commit_rdVal;
  logic [4:0]       rs1;
  logic [31:0]      rs1_val;
  logic             rs1_busy;
  logic [ROB_W-1:0] rs1_tag;
  logic [4:0]       rs2;
  logic [31:0]      rs2_val;
  logic             rs2_busy;
  logic [ROB_W-1:0] rs2_tag;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0]      mval  [32];
  logic             mbusy [32];
  logic [ROB_W-1:0] mtag  [32];

  rename_regfile #(.ROB_W(ROB_W)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_rdTag(commit_rdTag), .commit_rdVal(commit_rdVal),
    .rs1(rs1), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2(rs2), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mval[i] = '0; mbusy[i] = 1'b0; mtag[i] = '0;
    end
  endtask

  task automatic idle();
    rdy = 1'b1; rollback = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_rdTag = '0; commit_rdVal = '0;
  endtask

  task automatic expect_rd(input logic [4:0] r, output logic [31:0] v,
                           output logic b, output logic [ROB_W-1:0] t);
    v = (r == 0) ? 32'd0 : mval[r];
    b = (r == 0) ? 1'b0 : mbusy[r];
    t = (r == 0) ? '0 : mtag[r];
`ifdef RF_COMMIT_BYPASS_EN
    if (rdy && commit_valid && r != 0 && commit_rd == r
        && mbusy[r] && mtag[r] == commit_rdTag) begin
      b = 1'b0;
      v = commit_rdVal;
    end
`endif
  endtask

  // Check reads mid-cycle, then apply the spec's update rules at the edge.
  task automatic cyc();
    logic [31:0] v; logic b; logic [ROB_W-1:0] t;
    logic [31:0] nv [32]; logic nb [32]; logic [ROB_W-1:0] nt [32];
    @(negedge clk);
    expect_rd(rs1, v, b, t);
    chk("rs1_val", rs1_val, v);
    chk("rs1_busy", 32'(rs1_busy), 32'(b));
    chk("rs1_tag", 32'(rs1_tag), 32'(t));
    expect_rd(rs2, v, b, t);
    chk("rs2_val", rs2_val, v);
    chk("rs2_busy", 32'(rs2_busy), 32'(b));
    chk("rs2_tag", 32'(rs2_tag), 32'(t));
    @(posedge clk);
    nv = mval; nb = mbusy; nt = mtag;
    if (rdy) begin
      if (commit_valid && commit_rd != 0) begin
        nv[commit_rd] = commit_rdVal;
        if (mbusy[commit_rd] && mtag[commit_rd] == commit_rdTag)
          nb[commit_rd] = 1'b0;
      end
      if (rollback) begin
        for (int i = 0; i < 32; i++) begin nb[i] = 1'b0; nt[i] = '0; end
      end else if (issue_valid && issue_rd != 0) begin
        nb[issue_rd] = 1'b1;
        nt[issue_rd] = issue_tag;
      end
    end
    mval = nv; mbusy = nb; mtag = nt;
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [ROB_W-1:0] tg);
    idle(); issue_valid = 1'b1; issue_rd = rd; issue_tag = tg; cyc();
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [ROB_W-1:0] tg,
                           input logic [31:0] v);
    idle(); commit_valid = 1'b1; commit_rd = rd; commit_rdTag = tg;
    commit_rdVal = v; cyc();
  endtask

  initial begin
    rst_n = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
    idle(); model_reset();
    #2;
    chk("rst_rs1_val", rs1_val, 32'd0);
    chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
    chk("rst_rs2_tag", 32'(rs2_tag), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // rename then commit
    do_issue(5'd5, 4'd3);
    idle(); rs1 = 5'd5; #1;
    chk("t1_busy", 32'(rs1_busy), 32'd1);
    chk("t1_tag", 32'(rs1_tag), 32'd3);
    chk("t1_val", rs1_val, 32'd0);
    do_commit(5'd5, 4'd3, 32'hDEADBEEF);
    chk("t1c_busy", 32'(rs1_busy), 32'd0);
    chk("t1c_val", rs1_val, 32'hDEADBEEF);

    // stale commit keeps newer rename
    rs1 = 5'd7;
    do_issue(5'd7, 4'd2);
    do_issue(5'd7, 4'd6);
    do_commit(5'd7, 4'd2, 32'h11);
    chk("t2_val", rs1_val, 32'h11);
    chk("t2_busy", 32'(rs1_busy), 32'd1);
    chk("t2_tag", 32'(rs1_tag), 32'd6);
    do_commit(5'd7, 4'd6, 32'h22);
    chk("t2c_busy", 32'(rs1_busy), 32'd0);
    chk("t2c_val", rs1_val, 32'h22);

    // same-cycle issue and commit
    rs1 = 5'd9;
    do_issue(5'd9, 4'd1);
    idle(); issue_valid = 1'b1; issue_rd = 5'd9; issue_tag = 4'd4;
    commit_valid = 1'b1; commit_rd = 5'd9; commit_rdTag = 4'd1;
    commit_rdVal = 32'h55; cyc();
    idle(); #1;
    chk("t3_busy", 32'(rs1_busy), 32'd1);
    chk("t3_tag", 32'(rs1_tag), 32'd4);
    chk("t3_val", rs1_val, 32'h55);

    // rollback with dropped issue
    do_issue(5'd3, 4'd1);
    do_issue(5'd4, 4'd2);
    do_issue(5'd10, 4'd7);
    idle(); rollback = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3;
    issue_tag = 4'd8; cyc();
    idle(); rs1 = 5'd3; rs2 = 5'd10; #1;
    chk("t4_x3_busy", 32'(rs1_busy), 32'd0);
    chk("t4_x3_tag", 32'(rs1_tag), 32'd0);
    chk("t4_x10_busy", 32'(rs2_busy), 32'd0);
    rs1 = 5'd9; rs2 = 5'd5; #1;
    chk("t4_x9_busy", 32'(rs1_busy), 32'd0);
    chk("t4_x9_val", rs1_val, 32'h55);
    chk("t4_x5_val", rs2_val, 32'hDEADBEEF);

    // x0 writes ignored
    idle(); issue_valid = 1'b1; issue_rd = 5'd0; issue_tag = 4'd5;
    commit_valid = 1'b1; commit_rd = 5'd0; commit_rdVal = 32'hFF; cyc();
    idle(); rs1 = 5'd0; #1;
    chk("x0_val", rs1_val, 32'd0);
    chk("x0_busy", 32'(rs1_busy), 32'd0);
    chk("x0_tag", 32'(rs1_tag), 32'd0);

    // rdy low freezes state
    idle(); rdy = 1'b0; issue_valid = 1'b1; issue_rd = 5'd6; issue_tag = 4'd3;
    commit_valid = 1'b1; commit_rd = 5'd2; commit_rdVal = 32'h77; cyc();
    idle(); rs1 = 5'd6; rs2 = 5'd2; #1;
    chk("rdy_x6_busy", 32'(rs1_busy), 32'd0);
    chk("rdy_x2_val", rs2_val, 32'd0);

    // commit bypass
    do_issue(5'd12, 4'd5);
    idle(); commit_valid = 1'b1; commit_rd = 5'd12; commit_rdTag = 4'd5;
    commit_rdVal = 32'h1234; rs2 = 5'd12; #1;
`ifdef RF_COMMIT_BYPASS_EN
    chk("byp_busy", 32'(rs2_busy), 32'd0);
    chk("byp_val", rs2_val, 32'h1234);
`else
    chk("byp_busy", 32'(rs2_busy), 32'd1);
    chk("byp_val", rs2_val, 32'd0);
`endif
    chk("byp_tag", 32'(rs2_tag), 32'd5);
    cyc();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rdy          = ($urandom_range(0, 7) != 0);
      rollback     = ($urandom_range(0, 19) == 0);
      issue_valid  = $urandom_range(0, 1) == 1;
      issue_rd     = 5'($urandom_range(0, 31));
      issue_tag    = ROB_W'($urandom);
      commit_valid = $urandom_range(0, 1) == 1;
      commit_rd    = 5'($urandom_range(0, 31));
      commit_rdTag = ($urandom_range(0, 2) != 0) ? mtag[commit_rd]
                                                  : ROB_W'($urandom);
      commit_rdVal = $urandom;
      rs1 = ($urandom_range(0, 1) == 1) ? commit_rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 1) == 1) ? issue_rd : 5'($urandom_range(0, 31));
      cyc();
    end

    // asynchronous reset between edges
    do_commit(5'd1, 4'd0, 32'hAA55AA55);
    do_issue(5'd1, 4'd9);
    idle(); rs1 = 5'd1; rs2 = 5'd1; #1;
    chk("pre_rst_busy", 32'(rs1_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_val", rs1_val, 32'd0);
    chk("arst_busy", 32'(rs1_busy), 32'd0);
    chk("arst_tag", 32'(rs2_tag), 32'd0);
    model_reset();
    #3 rst_n = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
